// File: rtl/l2_arbiter_if.sv
// Bundles the I-cache, D-cache and L2 request/response signals that pass through the arbiter.
// The arbiter connects through the master modport. The L1 controllers and the L2 connect through the slave modport.
interface l2_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int MBE_W  = LINE_W / 8
);
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [MBE_W-1:0]  d_mbe;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   logic              l2_read;
   logic              l2_write;
   logic [ADDR_W-1:0] l2_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic [MBE_W-1:0]  l2_mbe;
   logic [LINE_W-1:0] l2_rdata;
   logic              l2_resp;

   modport master (
      input  i_read, i_addr,
      input  d_read, d_write, d_addr, d_wdata, d_mbe,
      input  l2_rdata, l2_resp,
      output i_rdata, i_resp, d_rdata, d_resp,
      output l2_read, l2_write, l2_addr, l2_wdata, l2_mbe
   );

   modport slave (
      output i_read, i_addr,
      output d_read, d_write, d_addr, d_wdata, d_mbe,
      output l2_rdata, l2_resp,
      input  i_rdata, i_resp, d_rdata, d_resp,
      input  l2_read, l2_write, l2_addr, l2_wdata, l2_mbe
   );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter that shares the single L2 request port between the L1 I-cache and D-cache.
// One transaction is in flight at a time. Each grant ends with one release cycle.
module l2_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int MBE_W  = 32
) (
   input  logic         clk,
   input  logic         rst,
   l2_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      RELEASE = 2'd3
   } state_t;

   state_t            state;
   logic              last_grant_d;
   logic              i_req;
   logic              d_req;

   logic              rd_mux;
   logic              wr_mux;
   logic [ADDR_W-1:0] addr_mux;
   logic [LINE_W-1:0] wdata_mux;
   logic [MBE_W-1:0]  mbe_mux;

   assign i_req = bus.i_read;
   assign d_req = bus.d_read | bus.d_write;

   // last_grant_d resets to D so that the first tie after reset goes to the I-cache.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         last_grant_d <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (i_req && d_req) begin
                  state <= last_grant_d ? GRANT_I : GRANT_D;
               end else if (i_req) begin
                  state <= GRANT_I;
               end else if (d_req) begin
                  state <= GRANT_D;
               end
            end
            GRANT_I: begin
               if (bus.l2_resp) begin
                  last_grant_d <= 1'b0;
                  state        <= RELEASE;
               end
            end
            GRANT_D: begin
               if (bus.l2_resp) begin
                  last_grant_d <= 1'b1;
                  state        <= RELEASE;
               end
            end
            RELEASE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // The L2 request follows the granted requester's live inputs. A D-cache write takes precedence over a D-cache read.
   always_comb begin
      // NOTE: every signal has a default before the case, so no case path infers a latch.
      rd_mux    = 1'b0;
      wr_mux    = 1'b0;
      addr_mux  = '0;
      wdata_mux = '0;
      mbe_mux   = '0;
      case (state)
         GRANT_I: begin
            rd_mux   = bus.i_read;
            addr_mux = bus.i_addr;
         end
         GRANT_D: begin
            wr_mux    = bus.d_write;
            rd_mux    = bus.d_read & ~bus.d_write;
            addr_mux  = bus.d_addr;
            wdata_mux = bus.d_wdata;
            mbe_mux   = bus.d_mbe;
         end
         default: ;
      endcase
   end

   assign bus.l2_read  = rd_mux;
   assign bus.l2_write = wr_mux;
   assign bus.l2_addr  = addr_mux;
   assign bus.l2_wdata = wdata_mux;
   assign bus.l2_mbe   = mbe_mux;

   assign bus.i_resp   = (state == GRANT_I) & bus.l2_resp;
   assign bus.d_resp   = (state == GRANT_D) & bus.l2_resp;
   assign bus.i_rdata  = bus.l2_rdata;
   assign bus.d_rdata  = bus.l2_rdata;

   // A requester must hold its request until its resp. Dropping it early is a protocol error.
   a_i_req_held: assert property (@(posedge clk) disable iff (rst)
      (state == GRANT_I) |-> bus.i_read);

   a_d_req_held: assert property (@(posedge clk) disable iff (rst)
      (state == GRANT_D) |-> (bus.d_read | bus.d_write));

   a_resp_exclusive: assert property (@(posedge clk) disable iff (rst)
      !(bus.i_resp && bus.d_resp));

endmodule
